// File: rtl/des_cbc_ctrl.sv
// ECB/CBC chaining controller between a block client and a single shared DES core.
// Optional key byte-parity checking is enabled with `define DES_CBC_CTRL_PARITY_EN.
module des_cbc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        mode_i,
  input  logic        cbc_i,
  input  logic [0:63] key_i,
  input  logic [0:63] data_i,
  input  logic        valid_i,
  output logic        accept_o,
  input  logic [0:63] iv_i,
  input  logic        iv_load_i,
  output logic [0:63] data_o,
  output logic        valid_o,
  input  logic        accept_i,
  output logic        des_mode_o,
  output logic [0:63] des_key_o,
  output logic [0:63] des_data_o,
  output logic        des_valid_o,
  input  logic        des_accept_i,
  input  logic [0:63] des_data_i,
  input  logic        des_valid_i,
  output logic        des_accept_o
`ifdef DES_CBC_CTRL_PARITY_EN
  ,
  output logic        err_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_OUT
  } state_t;

  state_t      state_reg;
  logic [0:63] chain_reg;
  logic [0:63] blk_data_reg;
  logic        blk_cbc_reg;
  logic        des_mode_reg;
  logic [0:63] des_key_reg;
  logic [0:63] des_data_reg;
  logic [0:63] data_out_reg;
  logic        accept_reg;
  logic        valid_out_reg;
  logic        des_valid_reg;
  logic        des_accept_reg;

  logic [0:63] chain_next;
  logic        in_xfer;
  logic        key_bad;

  // An IV loaded on the same edge as a block is the chain that block sees.
  assign chain_next = iv_load_i ? iv_i : chain_reg;
  assign in_xfer    = valid_i && accept_reg;

`ifdef DES_CBC_CTRL_PARITY_EN
  logic [7:0] key_byte_odd;
  logic       err_reg;

  for (genvar gi = 0; gi < 8; gi++) begin : g_key_parity
    assign key_byte_odd[gi] = ^key_i[8*gi +: 8];
  end

  assign key_bad = ~&key_byte_odd;
  assign err_o   = err_reg;
`else
  assign key_bad = 1'b0;
`endif

  assign accept_o     = accept_reg;
  assign valid_o      = valid_out_reg;
  assign data_o       = data_out_reg;
  assign des_mode_o   = des_mode_reg;
  assign des_key_o    = des_key_reg;
  assign des_data_o   = des_data_reg;
  assign des_valid_o  = des_valid_reg;
  assign des_accept_o = des_accept_reg;

  // Handshake flags are registered copies of the next-state decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      chain_reg      <= '0;
      blk_data_reg   <= '0;
      blk_cbc_reg    <= 1'b0;
      des_mode_reg   <= 1'b0;
      des_key_reg    <= '0;
      des_data_reg   <= '0;
      data_out_reg   <= '0;
      accept_reg     <= 1'b0;
      valid_out_reg  <= 1'b0;
      des_valid_reg  <= 1'b0;
      des_accept_reg <= 1'b0;
`ifdef DES_CBC_CTRL_PARITY_EN
      err_reg        <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (iv_load_i) begin
            chain_reg <= iv_i;
          end
          if (in_xfer) begin
            blk_data_reg <= data_i;
            blk_cbc_reg  <= cbc_i;
            des_mode_reg <= mode_i;
            des_key_reg  <= key_i;
            des_data_reg <= (cbc_i && !mode_i) ? (data_i ^ chain_next) : data_i;
            accept_reg   <= 1'b0;
            if (key_bad) begin
              // Bad key parity: report straight away without touching the core.
              state_reg     <= ST_OUT;
              data_out_reg  <= '0;
              valid_out_reg <= 1'b1;
`ifdef DES_CBC_CTRL_PARITY_EN
              err_reg       <= 1'b1;
`endif
            end else begin
              state_reg     <= ST_SEND;
              des_valid_reg <= 1'b1;
            end
          end else begin
            accept_reg <= 1'b1;
          end
        end

        ST_SEND: begin
          if (des_accept_i) begin
            state_reg      <= ST_WAIT;
            des_valid_reg  <= 1'b0;
            des_accept_reg <= 1'b1;
          end
        end

        ST_WAIT: begin
          if (des_valid_i) begin
            state_reg      <= ST_OUT;
            des_accept_reg <= 1'b0;
            valid_out_reg  <= 1'b1;
            if (blk_cbc_reg && des_mode_reg) begin
              data_out_reg <= des_data_i ^ chain_reg;
              chain_reg    <= blk_data_reg;
            end else if (blk_cbc_reg) begin
              data_out_reg <= des_data_i;
              chain_reg    <= des_data_i;
            end else begin
              data_out_reg <= des_data_i;
            end
          end
        end

        ST_OUT: begin
          if (accept_i) begin
            state_reg     <= ST_IDLE;
            valid_out_reg <= 1'b0;
            accept_reg    <= 1'b1;
`ifdef DES_CBC_CTRL_PARITY_EN
            err_reg       <= 1'b0;
`endif
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
